// File: rtl/mem_access_arbiter_pkg.sv
// Shared types for the CPU-side memory access arbiter in front of the SPI flash/PSRAM controller.
package mem_access_arbiter_pkg;

  localparam int unsigned ADDR_W  = 16;
  localparam int unsigned IWORD_W = 16;
  localparam int unsigned DBYTE_W = 8;
  localparam int unsigned TAG_W   = ADDR_W - 1;

  typedef enum logic [1:0] {
    TYPE_IMEM_READ  = 2'd0,
    TYPE_DMEM_WRITE = 2'd2,
    TYPE_DMEM_READ  = 2'd3
  } mem_type_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_START,
    ST_WAIT_DONE
  } arb_state_t;

endpackage

// File: rtl/mem_access_arbiter_ibuf_line.sv
// One-entry instruction word buffer: word-address tag, valid bit, 16-bit word and hit compare.
module ibuf_line
  import mem_access_arbiter_pkg::*;
(
  input  logic               clk_in,
  input  logic               reset_in,
  input  logic               load,
  input  logic [TAG_W-1:0]   load_tag,
  input  logic [IWORD_W-1:0] load_data,
  input  logic [TAG_W-1:0]   lookup_tag,
  output logic               hit_c,
  output logic [IWORD_W-1:0] data
);

  logic             valid;
  logic [TAG_W-1:0] tag;

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      valid <= 1'b0;
      tag   <= '0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      tag   <= load_tag;
      data  <= load_data;
    end
  end

  assign hit_c = valid && (tag == lookup_tag);

endmodule

// File: rtl/mem_access_arbiter.sv
// Arbitrates instruction fetches and data accesses onto the single SPI controller request port,
// with a one-word fetch buffer that answers repeated fetches without SPI traffic.
module mem_access_arbiter
  import mem_access_arbiter_pkg::*;
#(
  parameter bit IBUF_EN    = 1'b1,
  parameter bit DATA_FIRST = 1'b1
) (
  input  logic               clk_in,
  input  logic               reset_in,
  input  logic               imem_req_in,
  input  logic [ADDR_W-1:0]  imem_addr_in,
  output logic [IWORD_W-1:0] imem_data_out,
  output logic               imem_ack_out,
  input  logic               dmem_req_in,
  input  logic               dmem_we_in,
  input  logic [ADDR_W-1:0]  dmem_addr_in,
  input  logic [DBYTE_W-1:0] dmem_wdata_in,
  output logic [DBYTE_W-1:0] dmem_rdata_out,
  output logic               dmem_ack_out,
  output logic [ADDR_W-1:0]  mem_addr_out,
  output logic               mem_addr_valid_out,
  output mem_type_t          mem_type_out,
  output logic [DBYTE_W-1:0] mem_wdata_out,
  input  logic [IWORD_W-1:0] flash_data_in,
  input  logic               flash_data_valid_in,
  input  logic [DBYTE_W-1:0] psram_data_in,
  input  logic               psram_data_valid_in,
  input  logic               mem_busy_in
);

  arb_state_t         state_q, state_d;
  logic               last_data_q, last_data_d;
  logic [ADDR_W-1:0]  addr_d;
  mem_type_t          type_d;
  logic [DBYTE_W-1:0] wdata_d;
  logic               addr_valid_d;
  logic               iack_d, dack_d;
  logic [IWORD_W-1:0] idata_d;
  logic [DBYTE_W-1:0] rdata_d;
  logic               ibuf_load;
  logic               ibuf_hit_c;
  logic [IWORD_W-1:0] ibuf_data;

  ibuf_line u_ibuf (
    .clk_in     (clk_in),
    .reset_in   (reset_in),
    .load       (ibuf_load),
    .load_tag   (mem_addr_out[ADDR_W-1:1]),
    .load_data  (flash_data_in),
    .lookup_tag (imem_addr_in[ADDR_W-1:1]),
    .hit_c      (ibuf_hit_c),
    .data       (ibuf_data)
  );

  // A request whose ack is currently showing is already served; the requester drops it next edge.
  logic i_pend_c, d_pend_c, both_c, i_hit_c, pick_data_c;
  assign i_pend_c    = imem_req_in && !imem_ack_out;
  assign d_pend_c    = dmem_req_in && !dmem_ack_out;
  assign both_c      = i_pend_c && d_pend_c;
  assign i_hit_c     = IBUF_EN && ibuf_hit_c;
  assign pick_data_c = d_pend_c && (!i_pend_c || !last_data_q);

  // Next-state and next-output logic; last_data only records winners of real conflicts.
  always_comb begin
    state_d      = state_q;
    last_data_d  = last_data_q;
    addr_d       = mem_addr_out;
    type_d       = mem_type_out;
    wdata_d      = mem_wdata_out;
    addr_valid_d = 1'b0;
    iack_d       = 1'b0;
    dack_d       = 1'b0;
    idata_d      = imem_data_out;
    rdata_d      = dmem_rdata_out;
    ibuf_load    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pick_data_c) begin
          if (!mem_busy_in) begin
            state_d      = ST_ISSUE;
            addr_valid_d = 1'b1;
            addr_d       = dmem_addr_in;
            type_d       = dmem_we_in ? TYPE_DMEM_WRITE : TYPE_DMEM_READ;
            wdata_d      = dmem_wdata_in;
            if (both_c) last_data_d = 1'b1;
          end
        end else if (i_pend_c) begin
          if (i_hit_c) begin
            iack_d  = 1'b1;
            idata_d = ibuf_data;
            if (both_c) last_data_d = 1'b0;
          end else if (!mem_busy_in) begin
            state_d      = ST_ISSUE;
            addr_valid_d = 1'b1;
            addr_d       = {imem_addr_in[ADDR_W-1:1], 1'b0};
            type_d       = TYPE_IMEM_READ;
            if (both_c) last_data_d = 1'b0;
          end
        end
      end
      ST_ISSUE: state_d = ST_WAIT_START;
      ST_WAIT_START: begin
        if (mem_busy_in) state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        case (mem_type_out)
          TYPE_IMEM_READ: begin
            if (flash_data_valid_in) begin
              state_d   = ST_IDLE;
              iack_d    = 1'b1;
              idata_d   = flash_data_in;
              ibuf_load = 1'b1;
            end
          end
          TYPE_DMEM_READ: begin
            if (psram_data_valid_in) begin
              state_d = ST_IDLE;
              dack_d  = 1'b1;
              rdata_d = psram_data_in;
            end
          end
          default: begin
            if (!mem_busy_in) begin
              state_d = ST_IDLE;
              dack_d  = 1'b1;
            end
          end
        endcase
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state_q            <= ST_IDLE;
      last_data_q        <= ~DATA_FIRST;
      mem_addr_out       <= '0;
      mem_type_out       <= TYPE_IMEM_READ;
      mem_wdata_out      <= '0;
      mem_addr_valid_out <= 1'b0;
      imem_ack_out       <= 1'b0;
      imem_data_out      <= '0;
      dmem_ack_out       <= 1'b0;
      dmem_rdata_out     <= '0;
    end else begin
      state_q            <= state_d;
      last_data_q        <= last_data_d;
      mem_addr_out       <= addr_d;
      mem_type_out       <= type_d;
      mem_wdata_out      <= wdata_d;
      mem_addr_valid_out <= addr_valid_d;
      imem_ack_out       <= iack_d;
      imem_data_out      <= idata_d;
      dmem_ack_out       <= dack_d;
      dmem_rdata_out     <= rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Directed bench for mem_access_arbiter with a behavioural SPI controller model.
module tb_mem_access_arbiter;
  import mem_access_arbiter_pkg::*;

  localparam int LAT = 6;

  logic clk_in, reset_in;
  logic        imem_req_in, dmem_req_in, dmem_we_in;
  logic [15:0] imem_addr_in, dmem_addr_in;
  logic [7:0]  dmem_wdata_in;
  logic [15:0] imem_data_out, mem_addr_out;
  logic        imem_ack_out, dmem_ack_out, mem_addr_valid_out;
  logic [7:0]  dmem_rdata_out, mem_wdata_out;
  mem_type_t   mem_type_out;

  logic        nb_imem_req, nb_dmem_req, nb_dmem_we;
  logic [15:0] nb_imem_addr, nb_dmem_addr;
  logic [7:0]  nb_dmem_wdata;
  logic [15:0] nb_idata, nb_mem_addr;
  logic        nb_iack, nb_dack, nb_av;
  logic [7:0]  nb_rdata, nb_wdata;
  mem_type_t   nb_mem_type;

  logic [15:0] flash_data_in;
  logic        flash_data_valid_in, psram_data_valid_in, mem_busy_in;
  logic [7:0]  psram_data_in;

  mem_access_arbiter #(.IBUF_EN(1'b1), .DATA_FIRST(1'b1)) u_dut (
    .clk_in(clk_in), .reset_in(reset_in),
    .imem_req_in(imem_req_in), .imem_addr_in(imem_addr_in),
    .imem_data_out(imem_data_out), .imem_ack_out(imem_ack_out),
    .dmem_req_in(dmem_req_in), .dmem_we_in(dmem_we_in), .dmem_addr_in(dmem_addr_in),
    .dmem_wdata_in(dmem_wdata_in), .dmem_rdata_out(dmem_rdata_out), .dmem_ack_out(dmem_ack_out),
    .mem_addr_out(mem_addr_out), .mem_addr_valid_out(mem_addr_valid_out),
    .mem_type_out(mem_type_out), .mem_wdata_out(mem_wdata_out),
    .flash_data_in(flash_data_in), .flash_data_valid_in(flash_data_valid_in),
    .psram_data_in(psram_data_in), .psram_data_valid_in(psram_data_valid_in),
    .mem_busy_in(mem_busy_in)
  );

  mem_access_arbiter #(.IBUF_EN(1'b0), .DATA_FIRST(1'b1)) u_dut_nb (
    .clk_in(clk_in), .reset_in(reset_in),
    .imem_req_in(nb_imem_req), .imem_addr_in(nb_imem_addr),
    .imem_data_out(nb_idata), .imem_ack_out(nb_iack),
    .dmem_req_in(nb_dmem_req), .dmem_we_in(nb_dmem_we), .dmem_addr_in(nb_dmem_addr),
    .dmem_wdata_in(nb_dmem_wdata), .dmem_rdata_out(nb_rdata), .dmem_ack_out(nb_dack),
    .mem_addr_out(nb_mem_addr), .mem_addr_valid_out(nb_av),
    .mem_type_out(nb_mem_type), .mem_wdata_out(nb_wdata),
    .flash_data_in(flash_data_in), .flash_data_valid_in(flash_data_valid_in),
    .psram_data_in(psram_data_in), .psram_data_valid_in(psram_data_valid_in),
    .mem_busy_in(mem_busy_in)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  int n_vec = 0;
  int n_miss = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Controller model: flash/PSRAM byte arrays, transaction log, selected DUT
  logic [7:0]  flash_mem [256];
  logic [7:0]  psram_mem [256];
  bit          use_nb = 1'b0;
  int          txn_cnt = 0;
  logic [15:0] log_addr;
  logic [1:0]  log_type;
  logic [7:0]  log_wdata;
  bit          m_act;
  int          m_cnt;

  logic        sel_av;
  logic [15:0] sel_addr;
  logic [1:0]  sel_type;
  logic [7:0]  sel_wd;
  assign sel_av   = use_nb ? nb_av : mem_addr_valid_out;
  assign sel_addr = use_nb ? nb_mem_addr : mem_addr_out;
  assign sel_type = use_nb ? 2'(nb_mem_type) : 2'(mem_type_out);
  assign sel_wd   = use_nb ? nb_wdata : mem_wdata_out;

  initial begin
    mem_busy_in = 1'b0; flash_data_valid_in = 1'b0; psram_data_valid_in = 1'b0;
    flash_data_in = '0; psram_data_in = '0; m_act = 1'b0; m_cnt = 0;
    log_addr = '0; log_type = '0; log_wdata = '0;
    forever begin
      @(negedge clk_in);
      flash_data_valid_in = 1'b0;
      psram_data_valid_in = 1'b0;
      if (reset_in) begin
        mem_busy_in = 1'b0; m_act = 1'b0; m_cnt = 0;
      end else if (!m_act) begin
        if (sel_av) begin
          m_act = 1'b1; m_cnt = 0; txn_cnt++;
          log_addr = sel_addr; log_type = sel_type; log_wdata = sel_wd;
        end
      end else begin
        m_cnt++;
        if (m_cnt == 1) mem_busy_in = 1'b1;
        else if (m_cnt == LAT) begin
          case (log_type)
            2'd0: begin
              flash_data_in = {flash_mem[{log_addr[7:1], 1'b0}], flash_mem[{log_addr[7:1], 1'b1}]};
              flash_data_valid_in = 1'b1;
            end
            2'd3: begin
              psram_data_in = psram_mem[log_addr[7:0]];
              psram_data_valid_in = 1'b1;
            end
            default: psram_mem[log_addr[7:0]] = log_wdata;
          endcase
        end else if (m_cnt == LAT + 1) begin
          mem_busy_in = 1'b0; m_act = 1'b0;
        end
      end
    end
  end

  task automatic fetch(input bit nb, input logic [15:0] a, output logic [15:0] d,
                       output int lat, output int done);
    if (nb) begin nb_imem_addr = a; nb_imem_req = 1'b1; end
    else begin imem_addr_in = a; imem_req_in = 1'b1; end
    lat = 0; d = '0; done = 0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk_in);
      if (nb ? nb_iack : imem_ack_out) begin
        d = nb ? nb_idata : imem_data_out; lat = i; done = cyc;
        break;
      end
    end
    if (nb) nb_imem_req = 1'b0; else imem_req_in = 1'b0;
    if (lat == 0) chk("fetch_timeout", 32'(lat), 32'd1);
    @(negedge clk_in);
    chk("iack_one_cycle", 32'(nb ? nb_iack : imem_ack_out), 32'd0);
  endtask

  task automatic dmem(input bit we, input logic [15:0] a, input logic [7:0] wd,
                      output logic [7:0] rd, output int done);
    dmem_we_in = we; dmem_addr_in = a; dmem_wdata_in = wd; dmem_req_in = 1'b1;
    rd = '0; done = 0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk_in);
      if (dmem_ack_out) begin rd = dmem_rdata_out; done = cyc; break; end
    end
    dmem_req_in = 1'b0;
    if (done == 0) chk("dmem_timeout", 32'(done), 32'd1);
    @(negedge clk_in);
    chk("dack_one_cycle", 32'(dmem_ack_out), 32'd0);
  endtask

  logic [15:0] fd, fd2;
  logic [7:0]  rd;
  int lat, ic, dc, t0;
  bit seen;

  initial begin
    for (int i = 0; i < 256; i++) begin
      flash_mem[i] = 8'(i) ^ 8'h5A;
      psram_mem[i] = ~8'(i);
    end
    flash_mem[8'h10] = 8'h12;
    flash_mem[8'h11] = 8'h34;
    imem_req_in = 0; imem_addr_in = '0; dmem_req_in = 0; dmem_we_in = 0;
    dmem_addr_in = '0; dmem_wdata_in = '0;
    nb_imem_req = 0; nb_imem_addr = '0; nb_dmem_req = 0; nb_dmem_we = 0;
    nb_dmem_addr = '0; nb_dmem_wdata = '0;
    reset_in = 1'b1;
    repeat (3) @(negedge clk_in);
    chk("rst_iack", 32'(imem_ack_out), 0);
    chk("rst_av", 32'(mem_addr_valid_out), 0);
    chk("rst_type", 32'(mem_type_out), 0);
    chk("rst_nb_outs", 32'({nb_iack, nb_dack, nb_av, nb_rdata}), 0);
    reset_in = 1'b0;
    @(negedge clk_in);

    // Miss then hit on the same word
    t0 = txn_cnt;
    fetch(0, 16'h0010, fd, lat, ic);
    chk("miss_data", 32'(fd), 32'h1234);
    chk("miss_txns", 32'(txn_cnt - t0), 1);
    chk("miss_addr", 32'(log_addr), 32'h0010);
    chk("miss_type", 32'(log_type), 0);
    t0 = txn_cnt;
    fetch(0, 16'h0011, fd, lat, ic);
    chk("hit_data", 32'(fd), 32'h1234);
    chk("hit_latency", 32'(lat), 1);
    chk("hit_no_txn", 32'(txn_cnt - t0), 0);

    // Data write then read back
    dmem(1'b1, 16'h0200, 8'hA5, rd, dc);
    chk("wr_type", 32'(log_type), 2);
    chk("wr_addr", 32'(log_addr), 32'h0200);
    chk("wr_wdata", 32'(log_wdata), 32'hA5);
    dmem(1'b0, 16'h0200, 8'h00, rd, dc);
    chk("rd_type", 32'(log_type), 3);
    chk("rd_data", 32'(rd), 32'hA5);

    // First conflict: data wins; second conflict: fetch wins
    fork
      fetch(0, 16'h0020, fd, lat, ic);
      dmem(1'b0, 16'h0201, 8'h00, rd, dc);
    join
    chk("conf1_data_first", 32'(dc < ic), 1);
    chk("conf1_fdata", 32'(fd), 32'h7A7B);
    chk("conf1_rdata", 32'(rd), 32'hFE);
    fork
      fetch(0, 16'h0040, fd, lat, ic);
      dmem(1'b0, 16'h0203, 8'h00, rd, dc);
    join
    chk("conf2_fetch_first", 32'(ic < dc), 1);
    chk("conf2_fdata", 32'(fd), 32'h1A1B);
    chk("conf2_rdata", 32'(rd), 32'hFC);

    // Reset while a fetch is in WAIT_DONE, then refetch of a buffered word misses
    fetch(0, 16'h0050, fd, lat, ic);
    chk("pre_rst_data", 32'(fd), 32'h0A0B);
    imem_addr_in = 16'h0060; imem_req_in = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_in); #1;
      if (m_act && m_cnt == 3) begin seen = 1'b1; break; end
    end
    chk("reach_wait_done", 32'(seen), 1);
    #1 reset_in = 1'b1;
    #1;
    chk("rst_mid_addr", 32'(mem_addr_out), 0);
    chk("rst_mid_idata", 32'(imem_data_out), 0);
    chk("rst_mid_rdata", 32'(dmem_rdata_out), 0);
    chk("rst_mid_acks", 32'({imem_ack_out, dmem_ack_out, mem_addr_valid_out}), 0);
    chk("rst_mid_type_wd", 32'({2'(mem_type_out), mem_wdata_out}), 0);
    imem_req_in = 1'b0;
    @(negedge clk_in); #2 reset_in = 1'b0;
    @(negedge clk_in);
    t0 = txn_cnt;
    fetch(0, 16'h0050, fd, lat, ic);
    chk("post_rst_miss", 32'(txn_cnt - t0), 1);
    chk("post_rst_data", 32'(fd), 32'h0A0B);

    // Buffer disabled: every fetch goes to flash
    use_nb = 1'b1;
    t0 = txn_cnt;
    fetch(1, 16'h0010, fd, lat, ic);
    fetch(1, 16'h0010, fd2, lat, ic);
    chk("nb_data1", 32'(fd), 32'h1234);
    chk("nb_data2", 32'(fd2), 32'h1234);
    chk("nb_two_txns", 32'(txn_cnt - t0), 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
